// File: rtl/xm_mem_pkg.sv
// Shared definitions for the execute/memory latch consumer: opcode field,
// memory opcodes and the access FSM state encoding.
package xm_mem_pkg;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

   localparam logic [OPC_W-1:0] OP_SW = 5'b00111;
   localparam logic [OPC_W-1:0] OP_LW = 5'b01000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Extract the opcode field of an instruction word.
   function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] ir);
      return ir[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// REQ watchdog counter for xm_mem_access_ctrl. Only present when the
// MEM_TIMEOUT_EN macro is defined; without it there is no counter logic.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   // Count enabled cycles; clear has priority; hold once terminal count is hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc_c = (cnt == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/xm_mem_access_ctrl.sv
// xm_mem_access_ctrl: consumer end of the execute/memory latch. Runs a
// req/ack transaction to a variable-latency data memory for lw/sw, stalls
// the upstream latches meanwhile and loads the memory/writeback latch.
// Optional: MEM_TIMEOUT_EN adds a REQ watchdog that aborts with bus_err.
module xm_mem_access_ctrl
   import xm_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       xm_ir,
   input  logic [31:0]       xm_o,
   input  logic [31:0]       xm_b,
   input  logic              xm_ovf,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       mw_ir,
   output logic [31:0]       mw_o,
   output logic [31:0]       mw_d,
   output logic              mw_ovf,
   output logic              bus_err
);

   // Elaboration guard: the watchdog needs at least two REQ cycles to count.
   if (TIMEOUT_CYC < 2) begin : g_timeout_cyc_check
      $error("xm_mem_access_ctrl: TIMEOUT_CYC must be at least 2");
   end

   state_e              state, state_nxt;
   logic                is_mem_c;
   logic                stall_c;
   logic                mem_req_nxt, mem_we_nxt;
   logic [ADDR_W-1:0]   mem_addr_nxt;
   logic [31:0]         mem_wdata_nxt;
   logic [31:0]         hold_d, hold_d_nxt;
   logic [31:0]         mw_ir_nxt, mw_o_nxt, mw_d_nxt;
   logic                mw_ovf_nxt;
   logic                timeout_c;

`ifdef MEM_TIMEOUT_EN
   logic                bus_err_nxt;
   logic                to_clr, to_en;

   // Watchdog clears outside REQ and counts REQ cycles that see no ack.
   assign to_clr = (state != REQ);
   assign to_en  = (state == REQ) && !mem_ack;

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (to_clr),
      .en    (to_en),
      .tc_c  (timeout_c)
   );

   // Abort pulse: high for exactly the DONE cycle that follows a timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_err <= 1'b0;
      end else begin
         bus_err <= bus_err_nxt;
      end
   end
`else
   assign timeout_c = 1'b0;
   assign bus_err   = 1'b0;
`endif

   // Overflowed memory ops are demoted to plain pass-through.
   assign is_mem_c = ((opcode_of(xm_ir) == OP_SW) || (opcode_of(xm_ir) == OP_LW)) && !xm_ovf;

   // Reset forces the stall low at once so the upstream latches are not held.
   assign stall = stall_c && !reset;

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      state_nxt     = state;
      stall_c       = 1'b0;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      hold_d_nxt    = hold_d;
      mw_ir_nxt     = mw_ir;
      mw_o_nxt      = mw_o;
      mw_d_nxt      = mw_d;
      mw_ovf_nxt    = mw_ovf;
`ifdef MEM_TIMEOUT_EN
      bus_err_nxt   = 1'b0;
`endif

      unique case (state)
         IDLE: begin
            if (is_mem_c) begin
               stall_c       = 1'b1;
               state_nxt     = REQ;
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = (opcode_of(xm_ir) == OP_SW);
               mem_addr_nxt  = xm_o[ADDR_W-1:0];
               mem_wdata_nxt = xm_b;
               mw_ir_nxt     = '0;
            end else begin
               mw_ir_nxt  = xm_ir;
               mw_o_nxt   = xm_o;
               mw_d_nxt   = '0;
               mw_ovf_nxt = xm_ovf;
            end
         end

         REQ: begin
            stall_c   = 1'b1;
            mw_ir_nxt = '0;
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               hold_d_nxt  = mem_we ? 32'h0 : mem_rdata;
               state_nxt   = DONE;
            end else if (timeout_c) begin
               mem_req_nxt = 1'b0;
               hold_d_nxt  = '0;
               state_nxt   = DONE;
`ifdef MEM_TIMEOUT_EN
               bus_err_nxt = 1'b1;
`endif
            end
         end

         DONE: begin
            mw_ir_nxt  = xm_ir;
            mw_o_nxt   = xm_o;
            mw_d_nxt   = hold_d;
            mw_ovf_nxt = xm_ovf;
            state_nxt  = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, bus and memory/writeback latch registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hold_d    <= '0;
         mw_ir     <= '0;
         mw_o      <= '0;
         mw_d      <= '0;
         mw_ovf    <= 1'b0;
      end else begin
         state     <= state_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         hold_d    <= hold_d_nxt;
         mw_ir     <= mw_ir_nxt;
         mw_o      <= mw_o_nxt;
         mw_d      <= mw_d_nxt;
         mw_ovf    <= mw_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_xm_mem_access_ctrl.sv
// Scoreboard bench for xm_mem_access_ctrl with a behavioural memory model.
// Define MEM_TIMEOUT_EN to exercise the REQ watchdog (TIMEOUT_CYC = 4).
module tb_xm_mem_access_ctrl;

   localparam int unsigned TB_AW = 12;
   localparam int unsigned TB_TO = 4;
   localparam logic [4:0]  TB_OP_SW = 5'b00111;
   localparam logic [4:0]  TB_OP_LW = 5'b01000;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct { logic [31:0] ir; logic [31:0] o; logic [31:0] d; logic ovf; } mw_t;
   typedef struct { logic we; logic [TB_AW-1:0] addr; logic [31:0] wdata; } req_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      xm_ir, xm_o, xm_b;
   logic             xm_ovf;
   logic             stall, mem_req, mem_we, mem_ack, mw_ovf, bus_err;
   logic [TB_AW-1:0] mem_addr;
   logic [31:0]      mem_wdata, mem_rdata, mw_ir, mw_o, mw_d;

   int  errors = 0;
   int  checks = 0;
   bit  mon_en = 1'b0;
   bit  mem_en = 1'b0;

   mw_t  mw_q[$];
   req_t req_q[$];
   bit   berr_q[$];
   int   lat_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] bus_mem [int];

   xm_mem_access_ctrl #(
      .ADDR_W      (TB_AW),
      .TIMEOUT_CYC (TB_TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .xm_ir     (xm_ir),
      .xm_o      (xm_o),
      .xm_b      (xm_b),
      .xm_ovf    (xm_ovf),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .mw_ir     (mw_ir),
      .mw_o      (mw_o),
      .mw_d      (mw_d),
      .mw_ovf    (mw_ovf),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [31:0] init_word(input int a);
      return 32'h5A00_0000 ^ (32'(a) * 32'h0001_3579);
   endfunction

   function automatic logic [31:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic int rand_lat();
      int r;
      r = int'($urandom_range(0, 5));
`ifdef MEM_TIMEOUT_EN
      if (r == 0) return 1000;
      if (r == 1) return int'(TB_TO) - 1;
      return int'($urandom_range(0, TB_TO - 2));
`else
      if (r == 0) return 9;
      return int'($urandom_range(0, 3));
`endif
   endfunction

   // Memory responder: acks each request after its planned latency, pulses spurious acks when idle.
   initial begin
      int req_cyc = 0;
      int cur_lat = 0;
      int a;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mem_en) begin
            req_cyc = 0;
         end else if (mem_req) begin
            if (req_cyc == 0) begin
               if (lat_q.size() == 0) begin
                  fail_now("lat_q_empty");
                  cur_lat = 0;
               end else begin
                  cur_lat = lat_q.pop_front();
               end
            end
            if (req_cyc == cur_lat) begin
               a = int'(mem_addr);
               mem_ack = 1'b1;
               if (mem_we) begin
                  bus_mem[a] = mem_wdata;
                  mem_rdata  = $urandom();
               end else begin
                  mem_rdata = bus_mem.exists(a) ? bus_mem[a] : init_word(a);
               end
            end
            req_cyc++;
         end else begin
            req_cyc = 0;
            if ($urandom_range(0, 5) == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = $urandom();
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a result or a request.
   initial begin
      bit   prev_req = 1'b0;
      req_t cur;
      mw_t  e;
      cur = '{we: 1'b0, addr: '0, wdata: '0};
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (mw_ir != 32'h0) begin
               if (mw_q.size() == 0) begin
                  fail_now("mw_unexpected");
               end else begin
                  e = mw_q.pop_front();
                  check("mw_ir", mw_ir, e.ir);
                  check("mw_o", mw_o, e.o);
                  check("mw_d", mw_d, e.d);
                  check("mw_ovf", 32'(mw_ovf), 32'(e.ovf));
               end
            end
            if (mem_req && !prev_req) begin
               if (req_q.size() == 0) begin
                  fail_now("req_unexpected");
               end else begin
                  cur = req_q.pop_front();
                  check("req_we", 32'(mem_we), 32'(cur.we));
                  check("req_addr", 32'(mem_addr), 32'(cur.addr));
                  check("req_wdata", mem_wdata, cur.wdata);
               end
            end else if (mem_req) begin
               check("req_hold_we", 32'(mem_we), 32'(cur.we));
               check("req_hold_addr", 32'(mem_addr), 32'(cur.addr));
               check("req_hold_wdata", mem_wdata, cur.wdata);
            end
            if (prev_req && !mem_req) begin
               if (berr_q.size() == 0) fail_now("berr_q_empty");
               else check("bus_err", 32'(bus_err), 32'(berr_q.pop_front()));
            end else if (bus_err) begin
               fail_now("bus_err_unexpected");
            end
         end
         prev_req = mem_req;
      end
   end

   // Present one instruction on the xm latch, record expectations, hold it while stalled.
   task automatic run_instr(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                            input logic ovf, input int lat_in);
      logic [4:0]       opc;
      logic [TB_AW-1:0] a;
      logic [31:0]      d;
      bit               is_mem, abrt;
      int               occ, n, lat;
      logic             s;
      opc    = ir[31:27];
      is_mem = ((opc == TB_OP_SW) || (opc == TB_OP_LW)) && !ovf;
      a      = o[TB_AW-1:0];
      d      = '0;
      occ    = 1;
      if (is_mem) begin
         lat  = (lat_in < 0) ? rand_lat() : lat_in;
         abrt = TO_EN && (lat >= int'(TB_TO));
         occ  = abrt ? 2 + int'(TB_TO) : 3 + lat;
         req_q.push_back('{we: (opc == TB_OP_SW), addr: a, wdata: b});
         lat_q.push_back(lat);
         berr_q.push_back(abrt);
         if (!abrt) begin
            if (opc == TB_OP_SW) ref_mem[int'(a)] = b;
            else d = ref_read(int'(a));
         end
      end
      mw_q.push_back('{ir: ir, o: o, d: d, ovf: ovf});
      xm_ir  = ir;
      xm_o   = o;
      xm_b   = b;
      xm_ovf = ovf;
      n = 0;
      do begin
         @(negedge clk);
         s = stall;
         n++;
         @(posedge clk);
         #1;
      end while (s === 1'b1 && n < 300);
      check("occupancy", 32'(n), 32'(occ));
   endtask

   // Watchdog: guarantees termination even if the DUT never releases stall.
   initial begin
      #600000;
      fail_now("watchdog_time_limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      logic [4:0]  opc;
      logic [31:0] ir, o;
      int          k;
      reset  = 1'b1;
      xm_ir  = '0;
      xm_o   = '0;
      xm_b   = '0;
      xm_ovf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mw_ir", mw_ir, 32'h0);
      check("rst_mw_o", mw_o, 32'h0);
      check("rst_mw_d", mw_d, 32'h0);
      check("rst_mw_ovf", 32'(mw_ovf), 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      mem_en = 1'b1;

      // Directed cases: add pass-through, lw with two wait cycles, sw with immediate ack.
      run_instr(32'h0000_0001, 32'h0000_0015, 32'h0, 1'b0, -1);
      ref_mem[32'h234] = 32'hDEAD_BEEF;
      bus_mem[32'h234] = 32'hDEAD_BEEF;
      run_instr({TB_OP_LW, 27'h0000_123}, 32'h0000_1234, 32'h0, 1'b0, 2);
      run_instr({TB_OP_SW, 27'h0000_456}, 32'h0000_0100, 32'hCAFE_0001, 1'b0, 0);
      run_instr({TB_OP_LW, 27'h0000_777}, 32'h0000_0100, 32'h0, 1'b0, 1);
      run_instr({TB_OP_SW, 27'h0000_001}, 32'h0000_0040, 32'h1111_2222, 1'b1, -1);
`ifdef MEM_TIMEOUT_EN
      run_instr({TB_OP_LW, 27'h0000_0A5}, 32'h0000_0020, 32'h0, 1'b0, 1000);
      run_instr({TB_OP_LW, 27'h0000_0A6}, 32'h0000_0021, 32'h0, 1'b0, int'(TB_TO) - 1);
`endif

      // Randomized mix of lw/sw/other with a small address pool and occasional overflow.
      for (int i = 0; i < 160; i++) begin
         k = int'($urandom_range(0, 9));
         if (k < 4) opc = TB_OP_LW;
         else if (k < 7) opc = TB_OP_SW;
         else begin
            opc = 5'($urandom_range(0, 31));
            if (opc == TB_OP_LW || opc == TB_OP_SW) opc = 5'b00000;
         end
         ir = {opc, 26'($urandom()), 1'b1};
         o  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 15));
         run_instr(ir, o, $urandom(), ($urandom_range(0, 7) == 0), -1);
      end

      xm_ir  = '0;
      xm_ovf = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("mw_q_drained", 32'(mw_q.size()), 32'h0);
      check("req_q_drained", 32'(req_q.size()), 32'h0);

      // Asynchronous reset in the middle of a REQ that is never acknowledged.
      mon_en = 1'b0;
      mem_en = 1'b0;
      @(posedge clk);
      #1;
      xm_ir  = {TB_OP_LW, 27'h0000_001};
      xm_o   = 32'h0000_0055;
      xm_b   = 32'h0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midreq_req_before", 32'(mem_req), 32'h1);
      check("midreq_stall_before", 32'(stall), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("midreq_mem_req", 32'(mem_req), 32'h0);
      check("midreq_stall", 32'(stall), 32'h0);
      check("midreq_mw_ir", mw_ir, 32'h0);
      check("midreq_mw_o", mw_o, 32'h0);
      check("midreq_mw_d", mw_d, 32'h0);
      check("midreq_mw_ovf", 32'(mw_ovf), 32'h0);
      xm_ir = 32'h0000_0042;
      xm_o  = 32'h0000_0077;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;
      check("post_rst_mw_ir", mw_ir, 32'h0000_0042);
      check("post_rst_mw_o", mw_o, 32'h0000_0077);
      check("post_rst_mw_d", mw_d, 32'h0);
      check("post_rst_mem_req", 32'(mem_req), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xm_mem_access_ctrl.md
Name: xm_mem_access_ctrl

Overview:
- Consumer end of the execute/memory latch.
- Reads the latched instruction, ALU result, B operand and overflow flag, and runs a request/acknowledge transaction to a variable-latency data memory for lw/sw.
- Drives a stall back to the upstream latch enables and loads the memory/writeback latch outputs.
- Non-memory instructions pass through in one cycle.

Parameters:
- ADDR_W, 12, data-memory word address width; address = xm_o[ADDR_W-1:0], upper bits ignored.
- TIMEOUT_CYC, 64, REQ cycles allowed before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- xm_ir  in  32  instruction from execute/memory latch.
- xm_o  in  32  ALU result / effective address.
- xm_b  in  32  store data.
- xm_ovf  in  1  overflow flag.
- stall  out  1  combinational; 1 freezes PC and all upstream latch enables.
- mem_req  out  1  registered request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  load data, valid when mem_ack=1.
- mw_ir  out  32  to memory/writeback stage; 0 = bubble.
- mw_o  out  32  passed ALU result.
- mw_d  out  32  load data.
- mw_ovf  out  1  passed overflow.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Opcode = xm_ir[31:27]. OP_SW=00111, OP_LW=01000. is_mem = opcode is OP_SW or OP_LW, and xm_ovf=0.
- Reset (async): state=IDLE; mem_req, mem_we, bus_err = 0; mem_addr, mem_wdata = 0; all mw_* = 0; timeout counter = 0. Reset during REQ abandons the transaction; no ack is expected afterwards.
- States: IDLE, REQ, DONE (encoding in package).
- IDLE:
  - is_mem=0: stall=0; next edge loads mw_ir/mw_o/mw_ovf from xm_*, mw_d=0. Latency 1 cycle.
  - is_mem=1: stall=1; next edge goes to REQ and registers mem_req=1, mem_we=(opcode==OP_SW), mem_addr, mem_wdata=xm_b. mw_ir loads 0 (bubble).
- REQ: stall=1; mem_req stays 1; address, data and we held stable; mw_ir loads 0 each cycle.
  - mem_ack=1: capture mem_rdata (lw) or 0 (sw) into a data holding register; mem_req=0 at next edge; go to DONE.
- DONE: stall=0; next edge loads mw_ir=xm_ir, mw_o=xm_o, mw_d=held data, mw_ovf=xm_ovf; go to IDLE. The upstream latch advances on the same edge.
- Minimum memory-op occupancy is 3 cycles (IDLE, REQ with immediate ack, DONE); each extra wait cycle adds 1.
- mem_ack outside REQ is ignored.
- A mem op with xm_ovf=1 is treated as non-memory: no request, pass-through with mw_ovf=1.
- Back-to-back mem ops: DONE→IDLE, then the next instruction is evaluated normally. There is no idle cycle on the bus between requests other than the DONE/IDLE cycles.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYC-1 without ack: mem_req=0, held data=0, go to DONE, bus_err=1 for exactly that DONE cycle. An ack arriving on the expiry cycle wins (normal completion, no bus_err).
- Undefined: REQ waits indefinitely; bus_err is tied 0; no counter logic is present.

Decomposition:
- Package xm_mem_pkg holds:
  - opcode constants OP_SW and OP_LW;
  - the state enum (IDLE, REQ, DONE);
  - the opcode field slice positions [31:27].
- One natural sub-module: mem_timeout_ctr (clear, enable, terminal-count output), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- add (opcode 00000), xm_o=0x15, xm_ovf=0 → stall=0 throughout, mem_req never 1; next edge mw_ir=xm_ir, mw_o=0x15, mw_d=0.
- lw, xm_o=0x0000_1234, ADDR_W=12, ack 2 cycles after req with rdata=0xDEADBEEF → mem_addr=0x234, mem_we=0; stall high 4 cycles; after DONE mw_d=0xDEADBEEF, mw_ir=lw; bubbles (mw_ir=0) during the stall.
- sw, xm_b=0xCAFE0001, immediate ack → mem_we=1, mem_wdata=0xCAFE0001 stable while mem_req=1; 3-cycle occupancy; mw_d=0.
- lw then sw back-to-back, spurious mem_ack pulse in IDLE → spurious pulse ignored; two separate mem_req assertions, each with correct address and we.
- Reset asserted mid-REQ (async, between edges) → mem_req, stall, and all mw_* go 0 immediately; after release, state is IDLE and a following add passes in 1 cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, never ack → mem_req drops after 4 REQ cycles; bus_err pulses once; mw_d=0. Repeat with ack on the 4th cycle → no bus_err, data captured.
